cpu_multicycle_control: RTL
===========================

Name: cpu_multicycle_control

Overview:
- Multicycle successor to the single-cycle CPU control decoder.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Adds BNE and JR, a memory-ready handshake with a wait timeout, and a sticky fault state.
- Sits between the instruction register and the multicycle datapath muxes and enables.

Parameters:
- OPCODE_W, 6, opcode width; opcodes are zero-extended encodings below.
- MEM_TIMEOUT, 15, max consecutive mem_ready-low cycles in a memory state before fault; 0 disables the timeout.
- CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  opcode from the instruction register, sampled in DECODE
- mem_ready  in  1  memory completed the current access this cycle
- zero  in  1  ALU zero flag, valid in BRANCH
- pc_en  out  1  PC register load enable
- ir_write  out  1  instruction register load
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write
- reg_dst  out  2  write-register select: 0 = rt, 1 = rd, 2 = r31
- mem_to_reg  out  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2
- alu_op  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct, 11 = imm-opcode
- pc_source  out  2  next-PC select: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs
- err_code  out  2  sticky error: 00 none, 01 illegal opcode, 10 memory timeout
- state  out  4  current state, for debug/coverage

Behaviour:
- State codes: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, EXEC_I=8, R_WB=9, I_WB=10, BRANCH=11, JUMP=12, JR=13, FAULT=15.
- Reset (rst_n low, asynchronous): state=IDLE, wait counter=0, err_code=0. All outputs are 0 in IDLE. IDLE goes to FETCH on the first clock after reset release.
- Outputs are a function of state only, except pc_en in FETCH and BRANCH and ir_write in FETCH, as noted below. Any signal not listed for a state is 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=00, pc_source=0.
  - ir_write=pc_en=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
  - 0x00 goes to EXEC_R.
  - 0x01 (BEQ) and 0x0C (BNE) go to BRANCH.
  - 0x02 (LW) and 0x03 (SW) go to MEM_ADDR.
  - 0x04-0x07 (ADDI, ANDI, XORI, SLTI) go to EXEC_I.
  - 0x08 (J) and 0x09 (JAL) go to JUMP.
  - 0x0B (JR) goes to JR.
  - Any other opcode goes to FAULT with err_code=01.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=00. Goes to MEM_READ for LW, MEM_WRITE for SW. The opcode is held stable by the IR.
- MEM_READ: mem_read=1, i_or_d=1. Waits on mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Waits on mem_ready, then goes to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=10. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2. alu_op=00 for ADDI, 11 otherwise. Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=01, pc_source=1.
  - pc_en = zero for BEQ, ~zero for BNE.
  - Goes to FETCH.
- JUMP: pc_en=1, pc_source=2. For JAL also reg_write=1, reg_dst=2, mem_to_reg=2 (PC+4 into r31). Goes to FETCH.
- JR: pc_en=1, pc_source=3. Goes to FETCH.
- Wait counter:
  - Clears on every state change.
  - In FETCH, MEM_READ and MEM_WRITE it increments each cycle mem_ready=0 and saturates at MEM_TIMEOUT.
  - If the counter equals MEM_TIMEOUT (and MEM_TIMEOUT is nonzero) and mem_ready=0, the next state is FAULT with err_code=10.
  - mem_ready=1 in that same cycle wins: the access completes normally.
- FAULT: all outputs 0. Absorbing state; exits only via rst_n. err_code holds its value.
- Latency with mem_ready tied high:
  - R-type, I-type, SW: 4 cycles
  - LW: 5 cycles
  - BEQ, BNE, J, JAL, JR: 3 cycles
- Reset asserted mid-instruction: immediate return to IDLE; no partial write strobes after rst_n falls.

Test Plan:
- Reset then R-type (opcode 0x00), mem_ready=1 -> states 0,1,2,7,9,1; reg_write=1 and reg_dst=1 only in R_WB; pc_en=1 only in FETCH.
- LW (0x02) with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles with mem_read=1 and i_or_d=1; then MEM_WB with mem_to_reg=1; err_code=00.
- BEQ with zero=1, then BNE with zero=1 -> pc_en=1 in BRANCH for BEQ, pc_en=0 for BNE; pc_source=1 in both.
- JAL (0x09) -> JUMP state with pc_en=1, reg_write=1, reg_dst=2, mem_to_reg=2; JR (0x0B) -> pc_source=3.
- Opcode 0x3F -> DECODE then FAULT; err_code=01; all strobes 0 for 20 cycles; rst_n pulse returns state to IDLE, then FETCH.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> FAULT entered after 16 FETCH cycles with err_code=10; repeat with mem_ready=1 on the 16th FETCH cycle -> DECODE, no fault.

Source files
------------

// File: rtl/cpu_multicycle_control.sv
// Multicycle CPU control unit: a Moore FSM that sequences fetch, decode, execute,
// memory and writeback, with a memory-ready wait timeout and a sticky fault state.
module cpu_multicycle_control #(
  parameter int OPCODE_W    = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                pc_en,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [1:0]          err_code,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_R_WB      = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JR        = 4'd13,
    S_FAULT     = 4'd15
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(8'h00);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(8'h01);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(8'h02);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(8'h03);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(8'h04);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(8'h05);
  localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(8'h06);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(8'h07);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(8'h08);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(8'h09);
  localparam logic [OPCODE_W-1:0] OP_JR    = OPCODE_W'(8'h0B);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(8'h0C);
  localparam logic [CNT_W-1:0]    TIMEOUT  = CNT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic              in_wait;
  logic              timeout_hit;

  assign in_wait     = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  // A ready in the last allowed cycle completes the access instead of faulting.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TIMEOUT) && !mem_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        if (mem_ready) begin
          unique case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_MEM_READ: state_d = S_MEM_WB;
            default:    state_d = S_FETCH;
          endcase
        end else if (timeout_hit) begin
          state_d = S_FAULT;
          err_d   = 2'b10;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         state_d = S_EXEC_R;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_XORI, OP_SLTI: state_d = S_EXEC_I;
          OP_J, OP_JAL:                     state_d = S_JUMP;
          OP_JR:                            state_d = S_JR;
          default: begin
            state_d = S_FAULT;
            err_d   = 2'b01;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FETCH;
    endcase

    if (state_d != state_q)
      cnt_d = '0;
    else if (in_wait && !mem_ready && cnt_q != TIMEOUT)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'b00;
    pc_source  = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        pc_en     = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'd3;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
      end
      S_I_WB:     reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'd1;
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_en     = 1'b1;
        pc_source = 2'd2;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
      end
      S_JR: begin
        pc_en     = 1'b1;
        pc_source = 2'd3;
      end
      default: ;
    endcase
  end

  assign err_code = err_q;
  assign state    = state_q;

endmodule
